// File: rtl/mpemu_scale_mixsched_if.sv
// Bus bundle for the mixer: frame samples, gain register writes,
// the shared scale-multiplier port and the mixed output.
interface mpemu_scale_mixsched_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
);
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned GAIN_W   = 32;
  localparam int unsigned PROD_W   = 32;

  logic                         strobe;
  logic [SAMPLE_W*NUM_CH-1:0]   data;
  logic                         vol_we;
  logic [CH_W-1:0]              vol_addr;
  logic [GAIN_W-1:0]            vol_data;
  logic [SAMPLE_W-1:0]          mul_mpcand;
  logic [GAIN_W-1:0]            mul_scale;
  logic [PROD_W-1:0]            mul_mprod;
  logic [SAMPLE_W-1:0]          mix;
  logic                         mix_valid;
  logic                         busy;
  logic                         sat;
  logic                         overrun;

  // Mixer side
  modport slave (
    input  strobe, data, vol_we, vol_addr, vol_data, mul_mprod,
    output mul_mpcand, mul_scale, mix, mix_valid, busy, sat, overrun
  );

  // Source / multiplier / sink side
  modport master (
    output strobe, data, vol_we, vol_addr, vol_data, mul_mprod,
    input  mul_mpcand, mul_scale, mix, mix_valid, busy, sat, overrun
  );
endinterface

// File: rtl/mpemu_scale_mixsched.sv
// Time-shares one pipelined 24x32 scale multiplier across NUM_CH channels
// per frame, accumulates the products and emits one saturated 24-bit mix.
module mpemu_scale_mixsched #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned LATENCY = 6
) (
  input  logic clk,
  input  logic rst,
  mpemu_scale_mixsched_if.slave bus
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned GAIN_W   = 32;
  localparam int unsigned PROD_W   = 32;
  localparam int unsigned ACC_W    = PROD_W + CH_W;

  localparam logic [GAIN_W-1:0]          UNITY   = 32'h0100_0000;
  localparam logic [SAMPLE_W-1:0]        MIX_MAX = 24'h7F_FFFF;
  localparam logic [SAMPLE_W-1:0]        MIX_MIN = 24'h80_0000;
  localparam logic signed [ACC_W-1:0]    ACC_MAX = ACC_W'(MIX_MAX);
  localparam logic signed [ACC_W-1:0]    ACC_MIN = ~ACC_MAX;
  localparam logic [LATENCY-1:0]         TAG_OUT = LATENCY'(1) << (LATENCY - 1);
  localparam logic [CH_W-1:0]            LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state, state_nx;
  logic [CH_W-1:0]            ch, ch_nx;
  logic [SAMPLE_W-1:0]        sample [NUM_CH];
  logic [GAIN_W-1:0]          gain   [NUM_CH];
  logic [LATENCY-1:0]         tag;
  logic signed [ACC_W-1:0]    acc;

  logic [SAMPLE_W-1:0]        mpcand_q;
  logic [GAIN_W-1:0]          scale_q;
  logic [SAMPLE_W-1:0]        mix_q;
  logic                       mix_valid_q;
  logic                       busy_q;
  logic                       sat_q;
  logic                       overrun_q;

  logic                       start_c;
  logic                       fetch_c;
  logic [CH_W-1:0]            fetch_ch_c;
  logic [SAMPLE_W-1:0]        fetch_sample_c;
  logic [GAIN_W-1:0]          fetch_gain_c;
  logic                       retire_c;
  logic                       pending_c;
  logic signed [ACC_W-1:0]    prod_ext_c;
  logic signed [ACC_W-1:0]    acc_sum_c;
  logic [SAMPLE_W-1:0]        mix_sat_c;
  logic                       clip_c;

  assign bus.mul_mpcand = mpcand_q;
  assign bus.mul_scale  = scale_q;
  assign bus.mix        = mix_q;
  assign bus.mix_valid  = mix_valid_q;
  assign bus.busy       = busy_q;
  assign bus.sat        = sat_q;
  assign bus.overrun    = overrun_q;

  // State register and channel counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  // Next state; operands are fetched one cycle ahead so channel ch is on
  // the multiplier bus during the ISSUE cycle for ch
  always_comb begin
    state_nx   = state;
    ch_nx      = ch;
    start_c    = 1'b0;
    fetch_c    = 1'b0;
    fetch_ch_c = '0;
    case (state)
      IDLE: begin
        if (bus.strobe) begin
          state_nx   = ISSUE;
          ch_nx      = '0;
          start_c    = 1'b1;
          fetch_c    = 1'b1;
          fetch_ch_c = '0;
        end
      end
      ISSUE: begin
        if (ch == LAST_CH) begin
          state_nx = DRAIN;
        end else begin
          ch_nx      = ch + 1'b1;
          fetch_c    = 1'b1;
          fetch_ch_c = ch + 1'b1;
        end
      end
      DRAIN: begin
        if (!pending_c) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand selection; a gain write in the fetch cycle lands one cycle
  // later, exactly when that channel issues, so it is forwarded here
  always_comb begin
    fetch_sample_c = (state == IDLE) ? bus.data[SAMPLE_W-1:0] : sample[fetch_ch_c];
    fetch_gain_c   = gain[fetch_ch_c];
    if (bus.vol_we && (bus.vol_addr == fetch_ch_c)) fetch_gain_c = bus.vol_data;
  end

  // Retirement, accumulation and saturation of the running sum
  always_comb begin
    retire_c   = tag[LATENCY-1];
    pending_c  = |(tag & ~TAG_OUT);
    prod_ext_c = {{CH_W{bus.mul_mprod[PROD_W-1]}}, bus.mul_mprod};
    acc_sum_c  = retire_c ? (acc + prod_ext_c) : acc;
    clip_c     = 1'b0;
    mix_sat_c  = acc_sum_c[SAMPLE_W-1:0];
    if (acc_sum_c > ACC_MAX) begin
      mix_sat_c = MIX_MAX;
      clip_c    = 1'b1;
    end else if (acc_sum_c < ACC_MIN) begin
      mix_sat_c = MIX_MIN;
      clip_c    = 1'b1;
    end
  end

  // Gain registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_CH); k++) gain[k] <= UNITY;
    end else if (bus.vol_we) begin
      gain[bus.vol_addr] <= bus.vol_data;
    end
  end

  // Sample latch, operand registers, tag pipeline and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_CH); k++) sample[k] <= '0;
      mpcand_q <= '0;
      scale_q  <= '0;
      tag      <= '0;
      acc      <= '0;
    end else begin
      if (start_c) begin
        for (int k = 0; k < int'(NUM_CH); k++) sample[k] <= bus.data[SAMPLE_W*k +: SAMPLE_W];
      end
      if (fetch_c) begin
        mpcand_q <= fetch_sample_c;
        scale_q  <= fetch_gain_c;
      end
      tag <= (tag << 1) | LATENCY'(state == ISSUE);
      acc <= start_c ? '0 : acc_sum_c;
    end
  end

  // Mix output, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mix_valid_q <= (state_nx == DONE);
      if (state_nx == DONE) begin
        mix_q <= mix_sat_c;
        sat_q <= clip_c;
      end
      busy_q <= (state_nx != IDLE);
      if (bus.strobe && busy_q) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpemu_scale_mixsched.sv
// Self-checking bench for mpemu_scale_mixsched: directed vector table,
// multi-cycle corner sequences and randomized frames against a sum model.
module tb_mpemu_scale_mixsched;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned LATENCY = 6;
  localparam int unsigned EXP_LAT = NUM_CH + LATENCY + 1;
  localparam logic [31:0] UNITY   = 32'h0100_0000;

  typedef logic [NUM_CH-1:0][23:0] frame_t;
  typedef logic [NUM_CH-1:0][31:0] gains_t;

  typedef struct {
    frame_t      d;
    gains_t      g;
    logic [23:0] m;
    logic        s;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpemu_scale_mixsched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) ifc ();

  mpemu_scale_mixsched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_gain [NUM_CH];
  vec_t        vec [10];
  frame_t      fd;
  logic [23:0] em;
  logic        es;
  logic [31:0] rg;
  logic [1:0]  rc;
  logic [23:0] rs;

  // Behavioural shared multiplier: signed sample times 8.24 gain, LATENCY deep
  function automatic logic [31:0] mul_model(input logic [23:0] a, input logic [31:0] g);
    longint p;
    p = (longint'($signed(a)) * longint'(g)) >>> 24;
    return p[31:0];
  endfunction

  logic [31:0] mul_pipe [LATENCY];
  always @(posedge clk) begin
    mul_pipe[0] <= mul_model(ifc.mul_mpcand, ifc.mul_scale);
    for (int i = 1; i < int'(LATENCY); i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign ifc.mul_mprod = mul_pipe[LATENCY-1];

  // Reference mix: plain sum of scaled channels, clamped to 24-bit signed
  task automatic ref_mix(input frame_t d, output logic [23:0] m, output logic s);
    longint sum;
    sum = 0;
    for (int k = 0; k < int'(NUM_CH); k++)
      sum += (longint'($signed(d[k])) * longint'(model_gain[k])) >>> 24;
    s = 1'b1;
    if (sum > 64'sd8388607) m = 24'h7F_FFFF;
    else if (sum < -64'sd8388608) m = 24'h80_0000;
    else begin
      m = sum[23:0];
      s = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input logic [1:0] ch, input logic [31:0] g);
    ifc.vol_we   = 1'b1;
    ifc.vol_addr = ch;
    ifc.vol_data = g;
    tick();
    ifc.vol_we = 1'b0;
    model_gain[ch] = g;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) model_gain[k] = UNITY;
  endtask

  // One frame: strobe at cycle 0, optional extra strobe / gain write at a
  // frame-relative cycle, result checked at cycle EXP_LAT, idle at EXP_LAT+1
  task automatic do_frame(input frame_t d, input logic [23:0] exp_m, input logic exp_s,
                          input string name, input int xs_cyc, input int wr_cyc,
                          input logic [1:0] wr_ch, input logic [31:0] wr_val);
    int          pulses;
    int          lat;
    logic [23:0] got_m;
    logic        got_s;
    logic        busy_ok;
    pulses  = 0;
    lat     = 0;
    got_m   = '0;
    got_s   = 1'b0;
    busy_ok = 1'b1;
    ifc.data   = d;
    ifc.strobe = 1'b1;
    tick();
    ifc.strobe = 1'b0;
    for (int c = 1; c <= int'(EXP_LAT); c++) begin
      if (c == xs_cyc) ifc.strobe = 1'b1;
      if (c == wr_cyc) begin
        ifc.vol_we   = 1'b1;
        ifc.vol_addr = wr_ch;
        ifc.vol_data = wr_val;
      end
      @(negedge clk);
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      if (ifc.mix_valid === 1'b1) begin
        if (pulses == 0) begin
          lat   = c;
          got_m = ifc.mix;
          got_s = ifc.sat;
        end
        pulses++;
      end
      tick();
      ifc.strobe = 1'b0;
      if (c == wr_cyc) begin
        ifc.vol_we = 1'b0;
        model_gain[wr_ch] = wr_val;
      end
    end
    @(negedge clk);
    check({name, " latency"}, 32'(lat), 32'(EXP_LAT));
    check({name, " pulses"}, 32'(pulses), 32'd1);
    check({name, " mix"}, 32'(got_m), 32'(exp_m));
    check({name, " sat"}, 32'(got_s), 32'(exp_s));
    check({name, " busy during"}, 32'(busy_ok), 32'd1);
    check({name, " busy after"}, 32'(ifc.busy), 32'd0);
    check({name, " valid after"}, 32'(ifc.mix_valid), 32'd0);
  endtask

  // Watch n idle cycles: no mix pulse and busy low throughout
  task automatic watch_idle(input int n, input string name);
    int pulses;
    int busy_seen;
    pulses    = 0;
    busy_seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ifc.mix_valid !== 1'b0) pulses++;
      if (ifc.busy !== 1'b0) busy_seen++;
      tick();
    end
    check({name, " stray pulses"}, 32'(pulses), 32'd0);
    check({name, " stray busy"}, 32'(busy_seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.strobe   = 1'b0;
    ifc.data     = '0;
    ifc.vol_we   = 1'b0;
    ifc.vol_addr = '0;
    ifc.vol_data = '0;
    rst          = 1'b1;
    for (int k = 0; k < int'(NUM_CH); k++) model_gain[k] = UNITY;

    // d / g listed as {ch3, ch2, ch1, ch0}
    vec[0] = '{d: {24'h100000, 24'h100000, 24'h100000, 24'h100000},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h400000, s: 1'b0, name: "unity4"};
    vec[1] = '{d: {24'h800000, 24'h7ABCDE, 24'h123456, 24'hFFFFFF},
               g: {32'h0, 32'h0, 32'h0, 32'h0200_0000}, m: 24'hFFFFFE, s: 1'b0, name: "neg1x2"};
    vec[2] = '{d: {24'h300000, 24'h300000, 24'h300000, 24'h300000},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h7FFFFF, s: 1'b1, name: "sat_pos"};
    vec[3] = '{d: {24'h900000, 24'h900000, 24'h900000, 24'h900000},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h800000, s: 1'b1, name: "sat_neg"};
    vec[4] = '{d: {24'h000003, 24'h000003, 24'h000003, 24'h000003},
               g: {32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000},
               m: 24'h000004, s: 1'b0, name: "half_gain"};
    vec[5] = '{d: {24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h7FFFFF, s: 1'b0, name: "max_exact"};
    vec[6] = '{d: {24'h000000, 24'h000000, 24'h000001, 24'h7FFFFF},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h7FFFFF, s: 1'b1, name: "max_plus1"};
    vec[7] = '{d: {24'h000000, 24'h000000, 24'h000000, 24'h800000},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h800000, s: 1'b0, name: "min_exact"};
    vec[8] = '{d: {24'h400000, 24'h400000, 24'h400000, 24'h000100},
               g: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, m: 24'h00FFFF, s: 1'b0, name: "max_gain"};
    vec[9] = '{d: {24'hFFFFF0, 24'h000010, 24'hE00000, 24'h200000},
               g: {UNITY, UNITY, UNITY, UNITY}, m: 24'h000000, s: 1'b0, name: "cancel"};

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst mix", 32'(ifc.mix), 32'd0);
    check("rst mix_valid", 32'(ifc.mix_valid), 32'd0);
    check("rst busy", 32'(ifc.busy), 32'd0);
    check("rst sat", 32'(ifc.sat), 32'd0);
    check("rst overrun", 32'(ifc.overrun), 32'd0);
    check("rst mpcand", 32'(ifc.mul_mpcand), 32'd0);
    check("rst scale", ifc.mul_scale, 32'd0);

    // First frame straight out of reset relies on the unity reset gains
    do_frame(vec[0].d, vec[0].m, vec[0].s, "post_rst", 0, 0, 2'd0, 32'd0);

    // Vector table; operands must hold the last issued channel afterwards
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < int'(NUM_CH); k++) write_gain(2'(k), vec[i].g[k]);
      do_frame(vec[i].d, vec[i].m, vec[i].s, vec[i].name, 0, 0, 2'd0, 32'd0);
      check({vec[i].name, " hold mpcand"}, 32'(ifc.mul_mpcand), 32'(vec[i].d[NUM_CH-1]));
      check({vec[i].name, " hold scale"}, ifc.mul_scale, vec[i].g[NUM_CH-1]);
    end

    // Gain write in ch2's issue cycle keeps the old gain; next frame muted
    for (int k = 0; k < int'(NUM_CH); k++) write_gain(2'(k), UNITY);
    fd = {24'h100000, 24'h100000, 24'h100000, 24'h100000};
    do_frame(fd, 24'h400000, 1'b0, "wr_same_cycle", 0, 3, 2'd2, 32'd0);
    do_frame(fd, 24'h300000, 1'b0, "ch2_muted_b2b", 0, 0, 2'd0, 32'd0);
    // A write the cycle before ch3 issues is already in effect
    do_frame(fd, 24'h200000, 1'b0, "wr_prev_cycle", 0, 3, 2'd3, 32'd0);

    // Strobe while busy: ignored, sticky overrun
    for (int k = 0; k < int'(NUM_CH); k++) write_gain(2'(k), UNITY);
    check("overrun clear before", 32'(ifc.overrun), 32'd0);
    do_frame(fd, 24'h400000, 1'b0, "ovr_cyc3", 3, 0, 2'd0, 32'd0);
    check("overrun set", 32'(ifc.overrun), 32'd1);
    watch_idle(15, "ovr_cyc3");
    fd = {24'h050000, 24'h050000, 24'h050000, 24'h050000};
    do_frame(fd, 24'h140000, 1'b0, "after_ovr", 0, 0, 2'd0, 32'd0);
    check("overrun held", 32'(ifc.overrun), 32'd1);

    // Strobe in the DONE cycle also counts as an overrun
    do_reset();
    @(negedge clk);
    check("overrun rst", 32'(ifc.overrun), 32'd0);
    do_frame(fd, 24'h140000, 1'b0, "ovr_done", int'(EXP_LAT), 0, 2'd0, 32'd0);
    check("overrun done", 32'(ifc.overrun), 32'd1);
    watch_idle(15, "ovr_done");

    // Reset at cycle 5 of a frame: no result, gains back to unity
    write_gain(2'd1, 32'd0);
    write_gain(2'd3, 32'h0300_0000);
    ifc.data   = {24'h100000, 24'h100000, 24'h100000, 24'h100000};
    ifc.strobe = 1'b1;
    tick();
    ifc.strobe = 1'b0;
    repeat (4) tick();
    do_reset();
    watch_idle(20, "mid_rst");
    check("mid_rst mix", 32'(ifc.mix), 32'd0);
    check("mid_rst overrun", 32'(ifc.overrun), 32'd0);
    fd = {24'h100000, 24'h100000, 24'h100000, 24'h100000};
    do_frame(fd, 24'h400000, 1'b0, "after_mid_rst", 0, 0, 2'd0, 32'd0);

    // Randomized frames against the reference sum
    for (int f = 0; f < 24; f++) begin
      int nw;
      int gap;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) begin
        rc = 2'($urandom_range(0, 3));
        rg = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0200_0000);
        write_gain(rc, rg);
      end
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
      for (int k = 0; k < int'(NUM_CH); k++) begin
        rs = 24'($urandom);
        if ($urandom_range(0, 1) == 1) rs = 24'($signed(rs) >>> 3);
        fd[k] = rs;
      end
      ref_mix(fd, em, es);
      do_frame(fd, em, es, "rand", 0, 0, 2'd0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
